instr_pack_loader: RTL and testbench

//  Inverse of the pipeline's field splitter. Accepts MIPS instruction fields (op, rs, rt, rd,

---
 rtl/instr_pack_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_pack_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_pack_loader.sv
// -----------------------------------------------------------------------------
// instr_pack_loader
//
// Packs MIPS instruction fields (R/I/J formats) into 32-bit words and streams
// them into instruction memory through a registered write port. This is the
// inverse of the pipeline's field splitter. It is used on the boot path to load
// a program before the pipeline is released from reset.
//
// Ports
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   start                 1-cycle pulse that opens a load session (ignored in LOAD)
//   in_valid / in_ready   field bundle handshake (in_ready only in LOAD)
//   fmt                   0=R, 1=I, 2=J, 3=illegal (consumed, never written)
//   op,rs,rt,rd,shamt,
//   funct,imm16,target26  instruction fields, sampled on accept only
//   last                  bundle is the final word of the program
//   wr_en/wr_addr/wr_data imem write port; a word appears one cycle after accept
//   count                 legal words written this session
//   busy / done / err     in LOAD / in DONE / illegal fmt seen this session
// -----------------------------------------------------------------------------
module instr_pack_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  input  logic              last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                accept;
  logic                legal;

  function automatic logic [31:0] pack_word(
    input logic [1:0]  f,
    input logic [5:0]  op_f,
    input logic [4:0]  rs_f,
    input logic [4:0]  rt_f,
    input logic [4:0]  rd_f,
    input logic [4:0]  sh_f,
    input logic [5:0]  fn_f,
    input logic [15:0] imm_f,
    input logic [25:0] tgt_f
  );
    logic [31:0] w;
    case (f)
      FMT_R:   w = {op_f, rs_f, rt_f, rd_f, sh_f, fn_f};
      FMT_I:   w = {op_f, rs_f, rt_f, imm_f};
      FMT_J:   w = {op_f, tgt_f};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign accept = in_valid && (state_q == S_LOAD);
  assign legal  = (fmt != 2'd3);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (legal) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = pack_word(fmt, op, rs, rt, rd, shamt, funct, imm16, target26);
            ptr_d     = ptr_q + 1'b1;
            count_d   = count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          // Only a legal word can bring the session to its depth limit.
          if (last || (legal && (count_q + 1'b1 == DEPTH_C))) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over a write registered on the same edge, so an aborted
  // session never leaves a stray strobe behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= BASE_C;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_C;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign count    = count_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_instr_pack_loader.sv
module tb_instr_pack_loader;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, last;
  logic              in_ready, wr_en, busy, done, err;
  logic [1:0]        fmt;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm16;
  logic [25:0]       target26;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;

  int total = 0;
  int bad   = 0;
  int writes_seen = 0;

  always #5 clk = ~clk;

  instr_pack_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .target26(target26), .last(last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Session-level view: a session is open or not, and each legal word lands
  // at BASE_ADDR + (words already written).
  bit          m_open, m_finished, m_err, m_wr, m_valid;
  int          m_words;
  logic [31:0] m_data;
  int          m_addr;

  function automatic logic [31:0] model_pack(input int f, input int o, input int s, input int t,
                                             input int d, input int sh, input int fn,
                                             input int im, input int tg);
    longint w;
    if (f == 0)      w = (o << 26) + (s << 21) + (t << 16) + (d << 11) + (sh << 6) + fn;
    else if (f == 1) w = (o << 26) + (s << 21) + (t << 16) + im;
    else             w = (o * 64'h400_0000) + tg;
    return w[31:0];
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    m_wr = 1'b0;
    if (reset) begin
      m_open = 0; m_finished = 0; m_err = 0; m_words = 0; m_addr = BASE_ADDR; m_data = 0;
    end else if (!m_open) begin
      if (start) begin
        m_open = 1; m_finished = 0; m_err = 0; m_words = 0;
      end
    end else if (in_valid) begin
      if (fmt == 2'd3) begin
        m_err = 1;
      end else begin
        m_wr   = 1;
        m_addr = BASE_ADDR + m_words;
        m_data = model_pack(fmt, op, rs, rt, rd, shamt, funct, imm16, target26);
        m_words++;
      end
      if (last || m_words == DEPTH) begin
        m_open = 0; m_finished = 1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", in_ready, m_open);
      chk("busy",     busy,     m_open);
      chk("done",     done,     m_finished);
      chk("err",      err,      m_err);
      chk("count",    count,    m_words);
      chk("wr_en",    wr_en,    m_wr);
      chk("wr_addr",  wr_addr,  m_addr);
      chk("wr_data",  wr_data,  m_data);
      if (wr_en) writes_seen++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 0; in_valid = 0; last = 0; fmt = 0; op = 0; rs = 0; rt = 0; rd = 0;
    shamt = 0; funct = 0; imm16 = 0; target26 = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic put_r(input int o, s, t, d, sh, fn, input bit l);
    in_valid = 1; fmt = 0; op = 6'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d);
    shamt = 5'(sh); funct = 6'(fn); last = l;
  endtask

  initial begin
    m_valid = 0;
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_wr_addr", wr_addr, BASE_ADDR);
    chk("rst_ready", in_ready, 1'b0);
    reset = 0;
    tick();

    // 1: R pack
    do_start();
    put_r(0, 9, 10, 8, 0, 'h20, 1);
    tick(); idle_inputs();
    chk("t1_wr_en", wr_en, 1'b1);
    chk("t1_data", wr_data, 32'h012A4020);
    chk("t1_addr", wr_addr, 0);
    chk("t1_done", done, 1'b1);
    chk("t1_count", count, 1);
    tick();
    chk("t1_pulse", wr_en, 1'b0);

    // 2: I then J
    do_start();
    in_valid = 1; fmt = 1; op = 6'h23; rs = 29; rt = 8; imm16 = 16'hFFFC; last = 0;
    tick();
    chk("t2_i_data", wr_data, 32'h8FA8FFFC);
    chk("t2_i_addr", wr_addr, 0);
    fmt = 2; op = 6'h02; target26 = 26'h0100004; last = 1;
    tick(); idle_inputs();
    chk("t2_j_data", wr_data, 32'h08100004);
    chk("t2_j_addr", wr_addr, 1);
    chk("t2_count", count, 2);
    tick();

    // 3: back-to-back, last on the 4th
    do_start();
    writes_seen = 0;
    for (int i = 0; i < 4; i++) begin
      put_r(0, i, i + 1, i + 2, i, 'h21, i == 3);
      tick();
      chk("t3_addr", wr_addr, i);
      chk("t3_data", wr_data, model_pack(0, 0, i, i + 1, i + 2, i, 'h21, 0, 0));
    end
    idle_inputs();
    tick();
    chk("t3_writes", writes_seen, 4);
    chk("t3_done", done, 1'b1);

    // 4: depth limit, six bundles without last
    do_start();
    writes_seen = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; fmt = 1; op = 6'h08; rs = 1; rt = 2; imm16 = 16'(i * 3); last = 0;
      tick();
    end
    idle_inputs();
    tick();
    chk("t4_writes", writes_seen, 4);
    chk("t4_count", count, 4);
    chk("t4_ready", in_ready, 1'b0);
    chk("t4_done", done, 1'b1);

    // 5: illegal between two legal words
    do_start();
    writes_seen = 0;
    put_r(0, 1, 2, 3, 0, 'h20, 0); tick();
    in_valid = 1; fmt = 3; op = 6'h3F; last = 0; tick();
    chk("t5_no_write", wr_en, 1'b0);
    put_r(0, 4, 5, 6, 0, 'h22, 1); tick();
    chk("t5_addr", wr_addr, 1);
    idle_inputs(); tick();
    chk("t5_err", err, 1'b1);
    chk("t5_writes", writes_seen, 2);
    // start together with a bundle in DONE: bundle is not taken
    start = 1; put_r(0, 7, 7, 7, 0, 'h20, 1); tick(); start = 0;
    chk("t5_err_clear", err, 1'b0);
    chk("t5_no_accept", wr_en, 1'b0);
    idle_inputs(); tick();
    chk("t5_still_load", busy, 1'b1);

    // 6: start in LOAD ignored, then reset aborts a pending write
    put_r(0, 1, 1, 1, 0, 'h20, 0); tick(); idle_inputs();
    start = 1; tick(); start = 0;
    put_r(0, 2, 2, 2, 0, 'h20, 0); tick(); idle_inputs();
    chk("t6_ptr_kept", wr_addr, 1);
    put_r(0, 3, 3, 3, 0, 'h20, 0); reset = 1; tick(); idle_inputs();
    chk("t6_wr_en", wr_en, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", count, 0);
    chk("t6_data", wr_data, 0);
    reset = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
